rv3n_irq_ctrl: RTL

Machine-level interrupt controller for the rv3n core. It owns the timer compare register and synchronises the external interrupt line. It arbitrates the software, timer and external interrupt sources by fixed priority, and sequences one trap request at a time into the CSR/jump logic. It sits beside the CSR unit: it consumes `mtime` and the enable state, and hands back a trap cause and return PC.

---
 rtl/rv3n_irq_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/rv3n_irq_ctrl.sv
// rv3n machine-level interrupt controller: pending sources, fixed-priority
// arbitration and a single-outstanding trap request toward the CSR unit.
module rv3n_irq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_ext,
    input  logic            soft_set,
    input  logic            soft_clr,
    input  logic [63:0]     mtime,
    input  logic            cmp_wr_valid,
    input  logic            cmp_wr_hi,
    input  logic [XLEN-1:0] cmp_wr_data,
    input  logic            mie_global,
    input  logic [2:0]      mie_mask,
    input  logic            pipe_idle,
    input  logic [XLEN-1:0] pipe_pc,
    input  logic            mret_valid,
    output logic            trap_req_valid,
    input  logic            trap_req_ready,
    output logic [XLEN-1:0] trap_req_cause,
    output logic [XLEN-1:0] trap_req_epc,
    output logic [2:0]      irq_pending,
    output logic            in_service
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [XLEN-1:0] CAUSE_SOFT  = {1'b1, {(XLEN-5){1'b0}}, 4'h3};
    localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-5){1'b0}}, 4'h7};
    localparam logic [XLEN-1:0] CAUSE_EXT   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

    logic [1:0]             state_q, state_d;
    logic                   soft_q;
    logic                   timer_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [63:0]            cmp_q, cmp_d;
    logic [XLEN-1:0]        cause_q, cause_d;
    logic [XLEN-1:0]        epc_q, epc_d;
    logic [2:0]             pend;
    logic [2:0]             elig;
    logic [XLEN-1:0]        win_cause;

    assign pend = {sync_q[SYNC_STAGES-1], timer_q, soft_q};
    assign elig = pend & mie_mask & {3{mie_global}};

    always_comb begin
        cmp_d = cmp_q;
        if (cmp_wr_valid) begin
            if (cmp_wr_hi) cmp_d[63:32] = cmp_wr_data[31:0];
            else           cmp_d[31:0]  = cmp_wr_data[31:0];
        end
    end

    // ext > soft > timer
    always_comb begin
        win_cause = CAUSE_TIMER;
        if (elig[2])      win_cause = CAUSE_EXT;
        else if (elig[0]) win_cause = CAUSE_SOFT;
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        case (state_q)
            ST_IDLE: begin
                if ((|elig) && pipe_idle) begin
                    state_d = ST_REQ;
                    cause_d = win_cause;
                    epc_d   = pipe_pc;
                end
            end
            ST_REQ: begin
                if (trap_req_ready) state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (mret_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            soft_q  <= 1'b0;
            timer_q <= 1'b0;
            sync_q  <= '0;
            cmp_q   <= '1;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            // clear wins over a same-cycle set
            if (soft_clr)      soft_q <= 1'b0;
            else if (soft_set) soft_q <= 1'b1;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_ext};
            cmp_q   <= cmp_d;
            timer_q <= (mtime >= cmp_d);
        end
    end

    assign trap_req_valid = (state_q == ST_REQ);
    assign in_service     = (state_q == ST_SERVICE);
    assign trap_req_cause = cause_q;
    assign trap_req_epc   = epc_q;
    assign irq_pending    = pend;

endmodule
